// File: rtl/fft_unload.sv
// Result-side reader for the FFT core: walks bins 0..NUM_BINS-1 and streams |X[k]| on a valid/ready port.
// Define FFT_UNLOAD_BITREV_EN to present bit-reversed read addresses while bin_idx stays in natural order.
module fft_unload #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int NUM_BINS  = 2 ** (N - 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] dout,
    output logic [N-1:0]           add_rd,
    output logic                   rd_active,
    output logic                   bin_valid,
    input  logic                   bin_ready,
    output logic [N-1:0]           bin_idx,
    output logic [BIT_WIDTH-1:0]   bin_mag,
    output logic                   unload_done
);
    localparam int W = BIT_WIDTH;
    localparam logic [N-1:0] LAST_IDX = N'(NUM_BINS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic           fft_done_q;
    logic [N-1:0]   rd_idx_q, rd_idx_d;
    logic [N-1:0]   add_rd_q, add_rd_d;
    logic           pend_q, pend_d;
    logic [N-1:0]   pend_idx_q, pend_idx_d;
    logic [1:0]     count_q, count_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [N-1:0]   fifo_idx_q [0:1];
    logic [W-1:0]   fifo_mag_q [0:1];

    logic           start;
    logic           issue;
    logic           push;
    logic           pop;
    logic [1:0]     occ;
    logic [N-1:0]   issue_addr;
    logic [W-1:0]   re, im, ar, ai, mx, mn, mag;

`ifdef FFT_UNLOAD_BITREV_EN
    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_rev
        assign issue_addr[gi] = rd_idx_q[N-1-gi];
    end
`else
    assign issue_addr = rd_idx_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            fft_done_q <= 1'b1;
            rd_idx_q   <= '0;
            add_rd_q   <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fft_done_q <= fft_done;
            rd_idx_q   <= rd_idx_d;
            add_rd_q   <= add_rd_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage needs no reset: count_q gates everything read from it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= pend_idx_q;
            fifo_mag_q[wr_ptr_q] <= mag;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = READ;
            READ:  if (issue && (rd_idx_q == LAST_IDX)) state_d = DRAIN;
            DRAIN: if (!pend_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_active   = (state_q == READ) || ((state_q == DRAIN) && pend_q);
        unload_done = (state_q == DONE);
        bin_valid   = (count_q != 2'd0);
        bin_idx     = bin_valid ? fifo_idx_q[rd_ptr_q] : '0;
        bin_mag     = bin_valid ? fifo_mag_q[rd_ptr_q] : '0;
        add_rd      = issue ? issue_addr : add_rd_q;
    end

    always_comb begin
        start = (state_q == IDLE) && fft_done && !fft_done_q;
        pop   = (count_q != 2'd0) && bin_ready;
        push  = pend_q;
        occ   = count_q + {1'b0, pend_q};
        // Credit this cycle's pop so a steady ready stream sustains one bin per cycle.
        issue = (state_q == READ) && ((occ - {1'b0, pop}) < 2'd2);

        rd_idx_d   = rd_idx_q;
        if (start) begin
            rd_idx_d = '0;
        end else if (issue) begin
            rd_idx_d = rd_idx_q + 1'b1;
        end
        add_rd_d   = add_rd;
        pend_d     = issue;
        pend_idx_d = issue ? rd_idx_q : pend_idx_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    end

    // |x| of -2^(W-1) is 2^(W-1), which still fits unsigned W bits.
    always_comb begin
        re  = dout[2*W-1:W];
        im  = dout[W-1:0];
        ar  = re[W-1] ? (~re + 1'b1) : re;
        ai  = im[W-1] ? (~im + 1'b1) : im;
        mx  = (ar >= ai) ? ar : ai;
        mn  = (ar >= ai) ? ai : ar;
        mag = mx + {1'b0, mn[W-1:1]};
    end

endmodule

// File: tb/tb_fft_unload.sv
// Bench for fft_unload: model RAM behind add_rd, per-cycle stream checker, directed frames.
module tb_fft_unload;
    localparam int BW = 16;
    localparam int N  = 9;
    localparam int NB = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          fft_done;
    logic [31:0]   dout;
    logic [N-1:0]  add_rd;
    logic          rd_active;
    logic          bin_valid;
    logic          bin_ready;
    logic [N-1:0]  bin_idx;
    logic [BW-1:0] bin_mag;
    logic          unload_done;

    fft_unload #(.BIT_WIDTH(BW), .N(N), .NUM_BINS(NB)) dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .dout(dout),
        .add_rd(add_rd), .rd_active(rd_active), .bin_valid(bin_valid),
        .bin_ready(bin_ready), .bin_idx(bin_idx), .bin_mag(bin_mag),
        .unload_done(unload_done)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:511];
    always @(posedge clk) dout <= ram[add_rd];

    int n_cmp = 0;
    int n_bad = 0;

    // Natural bin index <-> RAM address; the mapping is its own inverse.
    function automatic int nat(input logic [8:0] a);
        logic [8:0] r;
`ifdef FFT_UNLOAD_BITREV_EN
        for (int i = 0; i < 9; i++) r[i] = a[8-i];
`else
        r = a;
`endif
        return int'(r);
    endfunction

    function automatic int model_mag(input logic [31:0] w);
        int re, im, ar, ai;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        return (ar > ai) ? ar + ai / 2 : ai + ar / 2;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream checker state
    int  exp_idx  = 0;
    int  last_acc = -1;
    bit  done_due = 1'b0;
    int  pulses   = 0;
    int  got_mag [0:511];
    bit  prev_valid = 1'b0, prev_ready = 1'b0;
    int  prev_idx = 0, prev_mag = 0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_idx    = 0;
            last_acc   = -1;
            done_due   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            chk("unload_done", unload_done, done_due);
            done_due = 1'b0;
            if (unload_done) pulses++;
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", bin_valid, 1);
                chk("stall_idx", bin_idx, prev_idx);
                chk("stall_mag", bin_mag, prev_mag);
            end
            if (bin_valid && bin_ready) begin
                chk("bin_idx", bin_idx, exp_idx);
                chk("bin_mag", bin_mag, model_mag(ram[nat(exp_idx[8:0])]));
                got_mag[exp_idx] = int'(bin_mag);
                last_acc = exp_idx;
                exp_idx++;
                if (exp_idx == NB) begin
                    done_due = 1'b1;
                    exp_idx  = 0;
                    last_acc = -1;
                end
            end
            if (rd_active && last_acc >= 0)
                chk("addr_lead", (nat(add_rd) <= last_acc + 2), 1);
            prev_valid = bin_valid;
            prev_ready = bin_ready;
            prev_idx   = int'(bin_idx);
            prev_mag   = int'(bin_mag);
        end
    end

    // Ready driver: constant 1 or pseudo-random, changed just after each rising edge.
    bit ready_rand = 1'b0;
    initial begin
        bin_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bin_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic load_ram();
        logic [15:0] k16;
        for (int k = 0; k < 512; k++) begin
            k16 = 16'(k);
            ram[nat(k[8:0])] = {k16, -k16};
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        fft_done = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int cnt = 0;
        @(negedge clk);
        while (!unload_done && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        chk({name, "_done_seen"}, unload_done, 1);
        @(negedge clk);
        fft_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_add_rd"}, add_rd, 0);
        chk({name, "_rd_active"}, rd_active, 0);
        chk({name, "_bin_valid"}, bin_valid, 0);
        chk({name, "_bin_idx"}, bin_idx, 0);
        chk({name, "_bin_mag"}, bin_mag, 0);
        chk({name, "_unload_done"}, unload_done, 0);
    endtask

    initial begin
        int p0;
        int cnt;
        load_ram();
        reset    = 1'b0;
        fft_done = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");

        // fft_done already high at release must not start a frame
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("idle_rd_active", rd_active, 0);
            chk("idle_bin_valid", bin_valid, 0);
        end
        fft_done = 1'b0;
        @(negedge clk);
        $display("reset release with fft_done high: stayed idle");

        // Frame 1: full-rate, pinned pipeline timing
        p0 = pulses;
        start_frame();
        @(negedge clk);
        chk("c1_rd_active", rd_active, 1);
        chk("c1_add_rd", add_rd, 0);
        chk("c1_bin_valid", bin_valid, 0);
        @(negedge clk);
`ifdef FFT_UNLOAD_BITREV_EN
        chk("c2_add_rd", add_rd, 256);
`else
        chk("c2_add_rd", add_rd, 1);
`endif
        chk("c2_bin_valid", bin_valid, 0);
        @(negedge clk);
        chk("c3_bin_valid", bin_valid, 1);
        chk("c3_bin_idx", bin_idx, 0);
        @(negedge clk);
`ifdef FFT_UNLOAD_BITREV_EN
        chk("c4_add_rd", add_rd, 384);
`else
        chk("c4_add_rd", add_rd, 3);
`endif
        chk("c4_bin_idx", bin_idx, 1);
        wait_done("frame1");
        chk("frame1_pulses", pulses - p0, 1);
        chk("frame1_mag10", got_mag[10], 15);
        chk("frame1_mag255", got_mag[255], 382);
        $display("frame 1: 256 bins at full rate, unload_done pulses %0d", pulses - p0);

        // Frame 2: random backpressure
        p0 = pulses;
        ready_rand = 1'b1;
        start_frame();
        wait_done("frame2");
        ready_rand = 1'b0;
        chk("frame2_pulses", pulses - p0, 1);
        chk("frame2_mag200", got_mag[200], 300);
        $display("frame 2: 256 bins under random backpressure, unload_done pulses %0d", pulses - p0);

        // Frame 3: corner magnitudes in bins 0..2
        ram[nat(9'd0)] = 32'h8000_0000;
        ram[nat(9'd1)] = 32'h8000_8000;
        ram[nat(9'd2)] = 32'hFFFF_0003;
        p0 = pulses;
        start_frame();
        wait_done("frame3");
        chk("corner_mag0", got_mag[0], 32768);
        chk("corner_mag1", got_mag[1], 49152);
        chk("corner_mag2", got_mag[2], 3);
        chk("frame3_pulses", pulses - p0, 1);
        $display("frame 3: corner bins mag %0d %0d %0d", got_mag[0], got_mag[1], got_mag[2]);
        load_ram();

        // Frame 4: abort with reset at bin 100
        p0 = pulses;
        start_frame();
        cnt = 0;
        while (!(bin_valid && bin_idx == 9'd100) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_reached_bin100", bin_idx, 100);
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        fft_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort_idle_rd_active", rd_active, 0);
        end
        chk("abort_no_done", pulses - p0, 0);
        $display("frame 4: aborted by reset at bin 100");

        // Frame 5: restart after abort
        p0 = pulses;
        got_mag[100] = -1;
        start_frame();
        wait_done("frame5");
        chk("frame5_pulses", pulses - p0, 1);
        chk("frame5_mag100", got_mag[100], 150);
        $display("frame 5: restarted frame completed, unload_done pulses %0d", pulses - p0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_unload.md
Name: fft_unload

Overview:
- Result-side reader for the FFT core: once the FFT signals completion, it drives the core's read address and streams out a magnitude for each spectral bin.
- It walks bins 0..NUM_BINS-1 with a 1-cycle RAM read latency and computes an approximate |X[k]|.
- Results are presented on a valid/ready stream with backpressure to the downstream consumer (peak detect / display logic).

Parameters:
- BIT_WIDTH, 16: width of each real/imag component; bin_mag width.
- N, 9: FFT log2 size; address width.
- NUM_BINS, 2**(N-1): number of bins read per frame (real input, so only the first half); legal range 1..2**N.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- fft_done  input  1  FFT completion level from the core; a frame starts on its rising edge.
- dout  input  2*BIT_WIDTH  FFT result word {real[31:16], imag[15:0]}, signed two's complement; valid 1 cycle after add_rd is presented.
- add_rd  output  N  read address to the FFT core.
- rd_active  output  1  high while the block owns the FFT read port; the top level muxes add_rd into the core with it.
- bin_valid  output  1  bin_idx/bin_mag valid.
- bin_ready  input  1  consumer accepts the word when bin_valid && bin_ready.
- bin_idx  output  N  natural-order bin index of the current word.
- bin_mag  output  BIT_WIDTH  unsigned magnitude estimate.
- unload_done  output  1  one-cycle pulse after the last bin is accepted.

Behaviour:
- Reset:
  - All outputs are 0; state IDLE; FIFO is flushed; in-flight count is 0.
  - The fft_done edge register resets to 1, so a level already high at reset release does not start a frame.
  - Reset mid-frame abandons the frame immediately and issues no unload_done.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - rd_active = 0.
  - On fft_done = 1 with the previous sample 0, go to READ with rd_idx = 0.
- READ:
  - rd_active = 1.
  - A read issues in a cycle when (fifo_count + inflight) < 2. add_rd = rd_idx that cycle, then rd_idx increments.
  - When rd_idx = NUM_BINS-1 is issued, go to DRAIN.
  - add_rd holds its last value in stall cycles.
- Pipeline:
  - Address in cycle t; dout sampled in cycle t+1.
  - Magnitude is registered into a 2-entry FIFO at the end of t+1.
  - bin_valid is visible in cycle t+2.
  - First bin_valid therefore comes 3 cycles after the fft_done rising edge is sampled.
  - Sustained throughput is 1 bin/cycle while bin_ready = 1.
- DRAIN:
  - rd_active = 1 until inflight = 0.
  - Go to DONE when inflight = 0 and the FIFO is empty.
- DONE: unload_done = 1 for one cycle, then IDLE.
- Magnitude:
  - ar = |real|, ai = |imag|, each BIT_WIDTH-bit unsigned (|-32768| = 32768).
  - bin_mag = max(ar, ai) + (min(ar, ai) >> 1).
  - Maximum value is 49152 for 16 bits, so no overflow and no saturation logic is needed.
- Stream rules:
  - Once bin_valid is asserted, bin_idx and bin_mag hold stable until accepted.
  - bin_idx increments by exactly 1 per accepted word, starting at 0.
- Simultaneous events:
  - A FIFO push and pop in the same cycle leave the count unchanged.
  - A rising edge of fft_done outside IDLE is ignored, and its edge history is consumed.
- Boundary: with NUM_BINS = 1, the block issues a single read and goes directly READ -> DRAIN.

Optional Feature:
- Macro: FFT_UNLOAD_BITREV_EN.
- Defined: add_rd = bit-reverse of rd_idx over N bits, for cores that leave results in bit-reversed order. bin_idx stays natural order.
- Undefined: add_rd = rd_idx. No reversal logic is built.

Test Plan:
- Reset held low with fft_done = 1, then released with fft_done staying 1 -> block stays IDLE, rd_active = 0, no bin_valid.
- fft_done 0->1, bin_ready = 1, model RAM returns {k, -k} for address k -> 256 words, bin_idx 0..255, bin_mag = k + (k >> 1); first bin_valid exactly 3 cycles after the edge; unload_done pulses once, 1 cycle after the last accept.
- Same frame with bin_ready toggled 1,0,0,1 pseudo-randomly:
  - No index is skipped or duplicated.
  - bin_idx/bin_mag are stable while stalled.
  - add_rd is never more than 2 ahead of the last accepted bin.
- Corner values: dout = {16'h8000, 16'h0000} -> bin_mag = 32768; dout = {16'h8000, 16'h8000} -> 49152; dout = {16'hFFFF, 16'h0003} -> 3.
- Assert reset (reset = 0) at bin 100, then release and pulse fft_done -> all outputs 0 in reset; new frame restarts at bin_idx 0; no unload_done from the aborted frame.
- With FFT_UNLOAD_BITREV_EN, N = 9 -> rd_idx 1 gives add_rd 256, rd_idx 3 gives add_rd 384, while bin_idx reads 1 and 3.
